// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry direction predictor.
// Define BTB_BHT_2BIT_EN for 2-bit saturating counters; otherwise a 1-bit last-outcome predictor.
module branch_target_buffer #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispred,
    output logic [31:0] fix_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W;

`ifdef BTB_BHT_2BIT_EN
    localparam int             CTR_W    = 2;
    localparam logic [CTR_W-1:0] CTR_RST  = 2'b01;
    localparam logic [CTR_W-1:0] CTR_INIT = 2'b10;
`else
    localparam int             CTR_W    = 1;
    localparam logic [CTR_W-1:0] CTR_RST  = 1'b0;
    localparam logic [CTR_W-1:0] CTR_INIT = 1'b1;
`endif

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Lookup: read-old semantics fall out of reading the registered table.
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    assign lk_idx      = pc_if[INDEX_W+1:2];
    assign lk_tag      = pc_if[31:INDEX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    // The predictor MSB is the taken decision in both builds.
    assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : 32'h0;

    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               tbl_we;
    logic [CTR_W-1:0]   ctr_d;
    logic [31:0]        target_d;

    assign up_idx = upd_pc[INDEX_W+1:2];
    assign up_tag = upd_pc[31:INDEX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign tbl_we = upd_valid && (up_hit || upd_taken);

    always_comb begin
        ctr_d    = CTR_INIT;
        target_d = upd_target;
        if (up_hit) begin
`ifdef BTB_BHT_2BIT_EN
            if (upd_taken) begin
                ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
            end else begin
                ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
            end
`else
            ctr_d = upd_taken;
`endif
            if (!upd_taken) begin
                target_d = target_q[up_idx];
            end
        end
    end

    always_comb begin
        mispred = 1'b0;
        if (upd_valid) begin
            mispred = (upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
        end
        fix_pc        = upd_taken ? upd_target : upd_pc + 32'd4;
        br_cnt_d      = br_cnt_q + {31'd0, upd_valid};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mispred};
    end

    // NOTE: the table is flops, not RAM, so every entry can take the async clear;
    // sequential state is assigned with <= so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_RST;
            end
            br_cnt_q      <= 32'h0;
            mispred_cnt_q <= 32'h0;
        end else begin
            if (tbl_we) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= target_d;
                ctr_q[up_idx]    <= ctr_d;
            end
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (default INDEX_W=6).
// Expectations follow the 1-bit predictor unless BTB_BHT_2BIT_EN is defined.
module tb_branch_target_buffer;

`ifdef BTB_BHT_2BIT_EN
    localparam bit TWO = 1'b1;
`else
    localparam bit TWO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispred;
    logic [31:0] fix_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispred         (mispred),
        .fix_pc          (fix_pc),
        .br_cnt          (br_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    typedef struct {
        logic [31:0] pc_if;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_fix;
        logic [31:0] e_br;
        logic [31:0] e_mc;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic uv, logic [31:0] upc, logic ut,
                                logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                                logic e_pt, logic [31:0] e_ptgt, logic e_mis,
                                logic [31:0] e_fix, logic [31:0] e_br, logic [31:0] e_mc);
        vec_t v;
        v.pc_if = pc;  v.uv = uv;     v.upc = upc;       v.ut = ut;
        v.utgt = utgt; v.upt = upt;   v.uptgt = uptgt;   v.e_pt = e_pt;
        v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_fix = e_fix;
        v.e_br = e_br; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at posedge+1, compare at negedge, then advance through the next edge.
    task automatic apply(vec_t v, string tag);
        pc_if           = v.pc_if;
        upd_valid       = v.uv;
        upd_pc          = v.upc;
        upd_taken       = v.ut;
        upd_target      = v.utgt;
        upd_pred_taken  = v.upt;
        upd_pred_target = v.uptgt;
        @(negedge clk);
        check({tag, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, v.e_pt});
        check({tag, ".pred_target"}, pred_target,         v.e_ptgt);
        check({tag, ".mispred"},     {31'd0, mispred},    {31'd0, v.e_mis});
        check({tag, ".fix_pc"},      fix_pc,              v.e_fix);
        check({tag, ".br_cnt"},      br_cnt,              v.e_br);
        check({tag, ".mispred_cnt"}, mispred_cnt,         v.e_mc);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    vec_t hs[7];
    int   m;

    initial begin
        //            pc_if        uv  upc           ut  utgt     upt uptgt    pt  ptgt     mis fix          br  mc
        vecs[0]  = mk(32'h100,  0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,       0,  0);
        vecs[1]  = mk(32'h100,  1, 32'h100,      1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80,      0,  0);
        vecs[2]  = mk(32'h100,  0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,       1,  1);
        vecs[3]  = mk(32'h100,  1, 32'h100,      1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 32'h90,      1,  1);
        vecs[4]  = mk(32'h100,  0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h4,       2,  2);
        vecs[5]  = mk(32'h100,  1, 32'h100,      1, 32'h90,  1, 32'h90,  1, 32'h90,  0, 32'h90,      2,  2);
        vecs[6]  = mk(32'h1100, 1, 32'h1100,     1, 32'h200, 0, 32'h0,   0, 32'h0,   1, 32'h200,     3,  2);
        vecs[7]  = mk(32'h100,  0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,       4,  3);
        vecs[8]  = mk(32'h1100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h4,       4,  3);
        vecs[9]  = mk(32'h1100, 1, 32'h2100,     0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h2104,    4,  3);
        vecs[10] = mk(32'h2100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,       5,  3);
        vecs[11] = mk(32'h1100, 1, 32'h104,      0, 32'h0,   1, 32'h0,   1, 32'h200, 1, 32'h108,     5,  3);
        vecs[12] = mk(32'h104,  1, 32'hFFFFFFFC, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,       6,  4);
        vecs[13] = mk(32'h1100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h4,       7,  4);

        // Predictor hysteresis and saturation on a fresh entry at 0x140.
        m = TWO ? 7 : 6;
        hs[0] = mk(32'h140, 1, 32'h140, 1, 32'h40, 0, 32'h0,  0, 32'h0, 1, 32'h40, 7, 4);
        hs[1] = mk(32'h140, 1, 32'h140, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 32'h40, 8, 5);
        hs[2] = mk(32'h140, 1, 32'h140, 0, 32'h0,  1, 32'h40, 1, 32'h40, 1, 32'h144, 9, 5);
        hs[3] = mk(32'h140, 1, 32'h140, 0, 32'h0,  TWO, 32'h40, TWO, TWO ? 32'h40 : 32'h0,
                   TWO, 32'h144, 10, 6);
        hs[4] = mk(32'h140, 1, 32'h140, 0, 32'h0,  0, 32'h0,  0, 32'h0, 0, 32'h144, 11, m);
        hs[5] = mk(32'h140, 1, 32'h140, 1, 32'h60, 0, 32'h0,  0, 32'h0, 1, 32'h60, 12, m);
        hs[6] = mk(32'h140, 0, 32'h0,   0, 32'h0,  0, 32'h0,  !TWO, TWO ? 32'h0 : 32'h60,
                   0, 32'h4, 13, m + 1);

        rst = 1'b1;
        pc_if = 32'h100; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 7; i++)  apply(hs[i],   $sformatf("hyst%0d", i));

        // Asynchronous reset between edges while an update is pending.
        pc_if = 32'h1100; upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1;
        upd_target = 32'h20; upd_pred_taken = 1'b1; upd_pred_target = 32'h20;
        #2;
        check("arst.pre_pred_taken", {31'd0, pred_taken}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst.pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("arst.pred_target", pred_target,          32'h0);
        check("arst.br_cnt",      br_cnt,               32'd0);
        check("arst.mispred_cnt", mispred_cnt,          32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(32'h180,  0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 0, 0), "post0");
        apply(mk(32'h1100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 0, 0), "post1");
        apply(mk(32'h140,  0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 0, 0), "post2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
